alu_nibble_seq: RTL and testbench
=================================

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4, at least 8; NIB = WIDTH/4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  command valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a command.
REQ-006 SHALL have port in_op  input  3  operation: 0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR, 6 SLT (signed x<y), 7 SEQ (x==y).
REQ-007 SHALL have ports in_x and in_y  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_res  output  WIDTH  result.
REQ-011 SHALL have ports out_carry, out_ow, out_neg, out_zero  output  1 each  result flags.
REQ-012 SHALL have ports alu_ctrl (3), alu_x (4), alu_y (4), alu_cin (1)  output  drive the external 4-bit combinational ALU.
REQ-013 SHALL have ports alu_s (4), alu_cout, alu_ow, alu_neg, alu_zero (1 each)  input  external ALU results, valid in the same cycle.

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-015 SHALL accept a command on a rising edge with in_valid&in_ready, register in_op/in_x/in_y, and enter RUN with nibble index 0; later input changes SHALL be ignored.
REQ-016 SHALL spend exactly NIB cycles in RUN, processing nibble k (bits 4k+3:4k, LSB nibble first) in the k-th RUN cycle and capturing alu_s into result bits 4k+3:4k on that cycle's closing edge.
REQ-017 For ADD, SHALL drive alu_ctrl=0, alu_x=x nibble, alu_y=y nibble, alu_cin=0 for nibble 0 and the registered alu_cout of the previous nibble otherwise.
REQ-018 For SUB, SLT, and SEQ, SHALL drive alu_ctrl=0, alu_y=~(y nibble), alu_cin=1 for nibble 0 and the previous alu_cout otherwise (two's-complement x-y); alu_ctrl=1 SHALL never be issued.
REQ-019 For NOT/AND/OR/XOR, SHALL drive alu_ctrl=2/3/4/5 respectively, alu_cin=0.
REQ-020 In IDLE and DONE, SHALL drive alu_ctrl, alu_x, alu_y, and alu_cin to 0.
REQ-021 After the last nibble, SHALL enter DONE with out_valid=1; latency is NIB+1 rising edges from the accept edge to the first cycle with out_valid=1 (5 for WIDTH=16).
REQ-022 SHALL hold out_valid and all out_* stable in DONE until out_valid&out_ready on an edge, then SHALL return to IDLE; a new command SHALL NOT be accepted on that same edge.
REQ-023 For ADD/SUB, SHALL set out_res = the WIDTH-bit sum, out_carry = the last-nibble alu_cout (SUB: 1 = no borrow), and out_ow = the last-nibble alu_ow.
REQ-024 For NOT/AND/OR/XOR, SHALL set out_res = the bitwise result, out_carry=0, and out_ow=0.
REQ-025 For SLT, SHALL set out_res = {0..., (diff MSB ^ last-nibble alu_ow)}.
REQ-026 For SEQ, SHALL set out_res = {0..., (diff == 0)}.
REQ-027 For SLT and SEQ, SHALL set out_carry=0 and out_ow=0.
REQ-028 For all ops, SHALL compute out_neg = out_res[WIDTH-1] and out_zero = (out_res==0) internally; alu_neg and alu_zero SHALL be unused.
REQ-029 SHALL wrap ADD/SUB modulo 2^WIDTH with no saturation.

Reset
REQ-030 While rst_n=0, SHALL immediately (asynchronously) force state=IDLE, nibble index=0, and in_ready=1.
REQ-031 While rst_n=0, SHALL immediately force out_valid=0, out_res=0, all flags=0, and all alu_* outputs=0.
REQ-032 Reset asserted in RUN or DONE SHALL discard the in-flight command with no result delivered.
REQ-033 The first command SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-034 ADD x=0x7FFF, y=0x0001 -> out_res=0x8000, ow=1, neg=1, carry=0, zero=0; out_valid in cycle 5 after accept.
REQ-035 SUB x=0x0000, y=0x0001 -> out_res=0xFFFF, carry=0, ow=0, neg=1; SUB 0x0005-0x0005 -> 0x0000, carry=1, zero=1.
REQ-036 SLT x=0x8000, y=0x0001 -> out_res=0x0001; SLT 0x0001 vs 0x8000 -> 0x0000, zero=1; SEQ 0x1234 vs 0x1234 -> 0x0001.
REQ-037 AND x=0x1234, y=0xFFFF -> alu_x sequence 4,3,2,1 in RUN cycles 1-4, alu_ctrl=3, out_res=0x1234.
REQ-038 XOR 0xA5A5^0xA5A5 with out_ready low 3 cycles -> out_valid stays 1, out_res=0x0000, zero=1 stable, in_ready=0 throughout.
REQ-039 rst_n pulsed low during RUN nibble 2 -> all outputs 0 at once, in_ready=1; after release, ADD 0x00FF+0x0001 -> 0x0100, carry=0.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU sequencer: steps a WIDTH-bit command through an external
// 4-bit combinational ALU one nibble per cycle, LSB nibble first.
module alu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ow,
  output logic             out_neg,
  output logic             out_zero,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       alu_x,
  output logic [3:0]       alu_y,
  output logic             alu_cin,
  input  logic [3:0]       alu_s,
  input  logic             alu_cout,
  input  logic             alu_ow,
  input  logic             alu_neg,
  input  logic             alu_zero,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE.

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_SEQ = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [WIDTH-5:0]  acc_q;
  logic              carry_q;
  logic [WIDTH-1:0]  res_q;
  logic              carry_out_q;
  logic              ow_q;
  logic              neg_q;
  logic              zero_q;

  logic              first_nib;
  logic              last_nib;
  logic [3:0]        x_nib;
  logic [3:0]        y_nib;
  logic [WIDTH-1:0]  full_s;
  logic [WIDTH-1:0]  fin_res;
  logic              fin_carry;
  logic              fin_ow;
  logic              unused_alu_flags;

  assign unused_alu_flags = alu_neg ^ alu_zero;

  assign first_nib   = (idx_q == '0);
  assign last_nib    = (idx_q == IDXW'(NIB - 1));
  assign x_nib       = x_q[idx_q*4 +: 4];
  assign y_nib       = y_q[idx_q*4 +: 4];
  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_res     = res_q;
  assign out_carry   = carry_out_q;
  assign out_ow      = ow_q;
  assign out_neg     = neg_q;
  assign out_zero    = zero_q;
  assign dbg_state_o = state_q;

  // SUB, SLT and SEQ all run as x + ~y + 1 on the adder path.
  always_comb begin
    alu_ctrl = 3'd0;
    alu_x    = 4'd0;
    alu_y    = 4'd0;
    alu_cin  = 1'b0;
    if (state_q == S_RUN) begin
      alu_x = x_nib;
      alu_y = y_nib;
      case (op_q)
        OP_ADD: alu_cin = first_nib ? 1'b0 : carry_q;
        OP_SUB, OP_SLT, OP_SEQ: begin
          alu_y   = ~y_nib;
          alu_cin = first_nib ? 1'b1 : carry_q;
        end
        default: alu_ctrl = op_q;
      endcase
    end
  end

  // Final result assembled from the earlier nibbles plus the live last-nibble ALU output.
  always_comb begin
    full_s    = {alu_s, acc_q};
    fin_res   = full_s;
    fin_carry = 1'b0;
    fin_ow    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        fin_carry = alu_cout;
        fin_ow    = alu_ow;
      end
      OP_SLT:  fin_res = WIDTH'(alu_s[3] ^ alu_ow);
      OP_SEQ:  fin_res = WIDTH'(full_s == '0);
      default: fin_res = full_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      op_q        <= 3'd0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      carry_out_q <= 1'b0;
      ow_q        <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            x_q     <= in_x;
            y_q     <= in_y;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q <= alu_cout;
          if (last_nib) begin
            res_q       <= fin_res;
            carry_out_q <= fin_carry;
            ow_q        <= fin_ow;
            neg_q       <= fin_res[WIDTH-1];
            zero_q      <= (fin_res == '0);
            state_q     <= S_DONE;
          end else begin
            acc_q[idx_q*4 +: 4] <= alu_s;
            idx_q               <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a behavioural 4-bit ALU attached to the
// alu_* ports; expected results are hand-computed constants.
module tb_alu_nibble_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_carry;
  logic        out_ow;
  logic        out_neg;
  logic        out_zero;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_x;
  logic [3:0]  alu_y;
  logic        alu_cin;
  logic [3:0]  alu_s;
  logic        alu_cout;
  logic        alu_ow;
  logic        alu_neg;
  logic        alu_zero;
  logic [1:0]  dbg_state;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int lat;
  logic [3:0] tx[4];
  logic [2:0] tc[4];
  logic       tcin[4];
  logic       any_valid;

  always #5 clk = ~clk;

  alu_nibble_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_carry(out_carry), .out_ow(out_ow), .out_neg(out_neg), .out_zero(out_zero),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin),
    .alu_s(alu_s), .alu_cout(alu_cout), .alu_ow(alu_ow), .alu_neg(alu_neg),
    .alu_zero(alu_zero), .dbg_state_o(dbg_state)
  );

  // External combinational 4-bit ALU.
  logic [4:0] add5;
  always_comb begin
    add5     = {1'b0, alu_x} + {1'b0, alu_y} + {4'd0, alu_cin};
    alu_s    = 4'd0;
    alu_cout = 1'b0;
    alu_ow   = 1'b0;
    case (alu_ctrl)
      3'd0: begin
        alu_s    = add5[3:0];
        alu_cout = add5[4];
        alu_ow   = (alu_x[3] == alu_y[3]) && (add5[3] != alu_x[3]);
      end
      3'd2:    alu_s = ~alu_x;
      3'd3:    alu_s = alu_x & alu_y;
      3'd4:    alu_s = alu_x | alu_y;
      3'd5:    alu_s = alu_x ^ alu_y;
      default: alu_s = 4'd0;
    endcase
    alu_neg  = alu_s[3];
    alu_zero = (alu_s == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called #0 after the accept edge; scrambles inputs and waits (bounded) for out_valid.
  task automatic collect();
    lat = 1;
    #1;
    in_valid = 1'b0;
    in_x     = 16'($urandom);
    in_y     = 16'($urandom);
    in_op    = 3'($urandom_range(0, 7));
    while (out_valid !== 1'b1 && lat < 20) begin
      if (lat <= 4) begin
        tx[lat-1]   = alu_x;
        tc[lat-1]   = alu_ctrl;
        tcin[lat-1] = alu_cin;
      end
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_x     = x;
    in_y     = y;
    @(posedge clk);
    collect();
  endtask

  task automatic expect_res(input string n, input logic [15:0] r, input logic c,
                            input logic o, input logic ng, input logic z);
    chk({n, "_lat"},   lat, 5);
    chk({n, "_res"},   out_res, r);
    chk({n, "_carry"}, out_carry, c);
    chk({n, "_ow"},    out_ow, o);
    chk({n, "_neg"},   out_neg, ng);
    chk({n, "_zero"},  out_zero, z);
    chk({n, "_inrdy"}, in_ready, 0);
  endtask

  task automatic release_res(input string n);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({n, "_idle_rdy"}, in_ready, 1);
    chk({n, "_idle_vld"}, out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_x      = 16'd0;
    in_y      = 16'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_state", dbg_state, 0);

    // First command presented together with reset release.
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_x     = 16'h7FFF;
    in_y     = 16'h0001;
    @(posedge clk);
    collect();
    expect_res("add_ow", 16'h8000, 0, 1, 1, 0);
    release_res("add_ow");

    issue(3'd1, 16'h0000, 16'h0001);
    chk("sub_cin0", tcin[0], 1);
    chk("sub_ctrl0", tc[0], 0);
    expect_res("sub_borrow", 16'hFFFF, 0, 0, 1, 0);
    release_res("sub_borrow");

    issue(3'd1, 16'h0005, 16'h0005);
    expect_res("sub_eq", 16'h0000, 1, 0, 0, 1);
    release_res("sub_eq");

    issue(3'd6, 16'h8000, 16'h0001);
    expect_res("slt_true", 16'h0001, 0, 0, 0, 0);
    release_res("slt_true");

    issue(3'd6, 16'h0001, 16'h8000);
    expect_res("slt_false", 16'h0000, 0, 0, 0, 1);
    release_res("slt_false");

    issue(3'd7, 16'h1234, 16'h1234);
    expect_res("seq_eq", 16'h0001, 0, 0, 0, 0);
    release_res("seq_eq");

    issue(3'd7, 16'h1234, 16'h1235);
    expect_res("seq_ne", 16'h0000, 0, 0, 0, 1);
    release_res("seq_ne");

    issue(3'd0, 16'h8000, 16'h8000);
    expect_res("add_wrap", 16'h0000, 1, 1, 0, 1);
    release_res("add_wrap");

    issue(3'd3, 16'h1234, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("and_alux%0d", k), tx[k], 4 - k);
      chk($sformatf("and_ctrl%0d", k), tc[k], 3);
      chk($sformatf("and_cin%0d", k), tcin[k], 0);
    end
    expect_res("and", 16'h1234, 0, 0, 0, 0);
    release_res("and");

    issue(3'd4, 16'h8001, 16'h00F0);
    expect_res("or", 16'h80F1, 0, 0, 1, 0);
    release_res("or");

    issue(3'd2, 16'h0F0F, 16'h0000);
    expect_res("not", 16'hF0F0, 0, 0, 1, 0);
    release_res("not");

    issue(3'd5, 16'hA5A5, 16'hA5A5);
    expect_res("xor", 16'h0000, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_vld", k), out_valid, 1);
      chk($sformatf("stall%0d_res", k), out_res, 16'h0000);
      chk($sformatf("stall%0d_zero", k), out_zero, 1);
      chk($sformatf("stall%0d_rdy", k), in_ready, 0);
    end

    // New command offered on the result handshake edge must wait one more edge.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_x      = 16'h0001;
    in_y      = 16'h0002;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_no_accept_rdy", in_ready, 1);
    chk("hs_no_accept_vld", out_valid, 0);
    @(posedge clk);
    collect();
    expect_res("add_after_hs", 16'h0003, 0, 0, 0, 0);
    release_res("add_after_hs");

    // Reset in RUN nibble 2.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_x     = 16'h5555;
    in_y     = 16'h1111;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_alux", alu_x, 4'h5);
    chk("pre_rst_aluy", alu_y, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_res", out_res, 0);
    chk("mid_rst_flags", {out_carry, out_ow, out_neg, out_zero}, 0);
    chk("mid_rst_alu", {alu_ctrl, alu_x, alu_y, alu_cin}, 0);
    chk("mid_rst_state", dbg_state, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) any_valid = 1'b1;
    end
    chk("rst_discard", any_valid, 0);

    issue(3'd0, 16'h00FF, 16'h0001);
    expect_res("add_post_rst", 16'h0100, 0, 0, 0, 0);
    release_res("add_post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
